// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Helpers shared by the read- and write-side controllers of the dual-clock
//   FIFO. Gray/binary conversion works on a fixed 32-bit word. Callers
//   zero-extend their pointer and keep the low bits of the result.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int GRAY_W = 32;

   typedef logic [GRAY_W-1:0] gray_word_t;

   // Adjacent binary values map to Gray codes differing in exactly one bit.
   function automatic gray_word_t bin2gray(input gray_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic gray_word_t gray2bin(input gray_word_t gray);
      gray_word_t bin;
      bin = gray;
      for (int i = GRAY_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_if
//   Valid/ready stream carrying words from the FIFO read controller to its
//   consumer.
//     out_valid  controller -> consumer  word available
//     out_data   controller -> consumer  word, held while stalled
//     out_ready  consumer -> controller  consumer accepts this cycle
//   master = producer side (controller), slave = consumer side.
// -----------------------------------------------------------------------------
interface fifo_rd_ctrl_if #(
   parameter int WIDTH = 4
);

   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      output out_ready
   );

endinterface

// File: rtl/fifo_sync2.sv
// -----------------------------------------------------------------------------
// fifo_sync2
//   Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
//   Only one bit of a Gray pointer changes per step, so a bus-wide
//   synchronizer cannot produce a value that is neither old nor new.
//     clk  destination-domain clock
//     rst  synchronous, active-high reset; clears both stages
//     d    asynchronous input bus
//     q    synchronized output (two destination edges of latency)
// -----------------------------------------------------------------------------
module fifo_sync2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // NOTE: non-blocking assignments let meta and q both sample their
   // pre-edge values, which forms a real two-stage pipeline. Blocking
   // assignments would collapse it to one flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//   Read-side controller of the dual-clock FIFO, entirely in the r_clk domain.
//   It keeps the read pointer, synchronizes the write pointer, derives the
//   empty flag, and issues reads to fifo_mem. It also parks the returned words
//   in a 2-entry output queue so the consumer can stall freely.
//     r_clk      read-domain clock
//     r_rst      synchronous, active-high reset
//     wptr_gray  write pointer (Gray, AW+1 bits) from the w_clk domain
//     rptr_gray  registered read pointer (Gray) to the write side
//     rd_rq      memory read request (combinational)
//     raddr      memory read address
//     empty      registered empty flag, also feeds the memory
//     rdata      memory read data, valid the cycle after rd_rq
//     out_if     valid/ready output stream (master side)
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             r_clk,
   input  logic             r_rst,
   input  logic [AW:0]      wptr_gray,
   output logic [AW:0]      rptr_gray,
   output logic             rd_rq,
   output logic [AW-1:0]    raddr,
   output logic             empty,
   input  logic [WIDTH-1:0] rdata,
   fifo_rd_ctrl_if.master   out_if
);

   logic [AW:0]      wq2;
   logic [AW:0]      rptr_bin;
   logic [AW:0]      rptr_bin_next;
   gray_word_t       gray_next;

   logic [1:0]       count;
   logic [1:0]       count_next;
   logic [1:0]       wr_idx;
   logic             pending;
   logic             push;
   logic             pop;
   logic [2:0]       in_use;
   logic [WIDTH-1:0] obuf [2];

   // ---------------------------------------------------------------- sync --
   fifo_sync2 #(
      .W (AW + 1)
   ) u_wptr_sync (
      .clk (r_clk),
      .rst (r_rst),
      .d   (wptr_gray),
      .q   (wq2)
   );

   // ------------------------------------------------------ issue / credit --
   // A word returns one cycle after its request (pending). It is pushed at
   // the end of that cycle. Counting in-flight words as occupied means a
   // read is issued only when the queue is guaranteed a free slot on arrival.
   assign push   = pending;
   assign pop    = out_if.out_valid && out_if.out_ready;
   assign in_use = {1'b0, count} + {2'b0, pending} - {2'b0, pop};
   assign rd_rq  = !empty && (in_use < 3'd2);

   assign rptr_bin_next = rptr_bin + {{AW{1'b0}}, rd_rq};
   assign gray_next     = bin2gray(GRAY_W'(rptr_bin_next));
   assign raddr         = rptr_bin[AW-1:0];

   // ---------------------------------------------------- queue bookkeeping --
   // NOTE: every output of a combinational block gets a default before any
   // condition, so no path leaves a variable unassigned and no latch forms.
   always_comb begin
      wr_idx     = count;
      count_next = count;
      if (pop) begin
         wr_idx = count - 2'd1;
      end
      count_next = wr_idx + {1'b0, push};
   end

   // ------------------------------------------------------------- state --
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         rptr_bin  <= '0;
         rptr_gray <= '0;
         empty     <= 1'b1;
         count     <= '0;
         pending   <= 1'b0;
         // NOTE: the two queue slots are reset on purpose. out_data shows the
         // head slot directly, so it must read 0 after reset, not stale data.
         obuf[0]   <= '0;
         obuf[1]   <= '0;
      end else begin
         rptr_bin  <= rptr_bin_next;
         rptr_gray <= gray_next[AW:0];
         // Compare the post-increment pointer so empty already accounts for
         // the read issued this cycle.
         empty     <= (gray_next == GRAY_W'(wq2));
         pending   <= rd_rq;
         count     <= count_next;
         // Pop shifts the tail into the head. A push in the same cycle lands
         // in the slot left after the pop. It is written last, so it wins
         // when that slot is the head.
         if (pop) begin
            obuf[0] <= obuf[1];
         end
         if (push) begin
            obuf[wr_idx[0]] <= rdata;
         end
      end
   end

   // ------------------------------------------------------------ outputs --
   assign out_if.out_valid = (count != 2'd0);
   assign out_if.out_data  = obuf[0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//   Directed bench for fifo_rd_ctrl (WIDTH 4, DEPTH 8). A behavioural memory
//   plus write-side pointer model feeds the DUT. Every word written is queued
//   as the expected output. A negedge monitor pops and compares on each
//   accepted word. It also checks hold stability, raddr/rptr_gray against a
//   read counter, and no read while empty.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;
   import fifo_pkg::*;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             r_clk = 1'b0;
   logic             r_rst;
   logic [AW:0]      wptr_gray;
   logic [AW:0]      rptr_gray;
   logic             rd_rq;
   logic [AW-1:0]    raddr;
   logic             empty;
   logic [WIDTH-1:0] rdata;

   fifo_rd_ctrl_if #(.WIDTH(WIDTH)) out_if ();

   fifo_rd_ctrl #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .r_clk     (r_clk),
      .r_rst     (r_rst),
      .wptr_gray (wptr_gray),
      .rptr_gray (rptr_gray),
      .rd_rq     (rd_rq),
      .raddr     (raddr),
      .empty     (empty),
      .rdata     (rdata),
      .out_if    (out_if)
   );

   always #5 r_clk = ~r_clk;

   // ------------------------------------------------------------- models --
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] exp_q [$];
   int               wbin;
   int               rd_cnt;
   int               n_vec = 0;
   int               n_mis = 0;
   int               n_out = 0;
   logic             chk_cnt = 1'b0;
   logic             wrap_seen = 1'b0;

   // Memory read port: one-cycle latency, zero when not reading.
   always @(posedge r_clk) begin
      rdata <= rd_rq ? mem[raddr] : '0;
   end

   // Count reads issued; the expected read address and pointer follow it.
   initial begin
      rd_cnt = 0;
      forever begin
         @(posedge r_clk);
         if (r_rst)      rd_cnt = 0;
         else if (rd_rq) rd_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge r_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge r_clk);
   endtask

   task automatic push_word(input logic [WIDTH-1:0] d);
      mem[3'(wbin)] = d;
      wbin++;
      wptr_gray = 4'(bin2gray(32'(wbin & 15)));
      exp_q.push_back(d);
   endtask

   task automatic do_reset();
      cyc();
      r_rst     = 1'b1;
      wbin      = 0;
      wptr_gray = '0;
      exp_q.delete();
      repeat (2) cyc();
      r_rst = 1'b0;
   endtask

   // ------------------------------------------------------------ monitor --
   initial begin
      logic             hold_v;
      logic [WIDTH-1:0] hold_d;
      logic [AW-1:0]    last_raddr;
      hold_v     = 1'b0;
      hold_d     = '0;
      last_raddr = '0;
      forever begin
         @(negedge r_clk);
         if (r_rst) begin
            hold_v     = 1'b0;
            last_raddr = '0;
         end else begin
            if (hold_v) begin
               check("hold_valid", 32'(out_if.out_valid), 32'd1);
               check("hold_data", 32'(out_if.out_data), 32'(hold_d));
            end
            if (out_if.out_valid && out_if.out_ready) begin
               check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  check("out_data", 32'(out_if.out_data), 32'(exp_q.pop_front()));
               end
               n_out++;
            end
            hold_v = out_if.out_valid && !out_if.out_ready;
            hold_d = out_if.out_data;
            check("rptr_gray", 32'(rptr_gray), bin2gray(32'(rd_cnt & 15)));
            if (rd_rq) begin
               check("raddr", 32'(raddr), 32'(rd_cnt & 7));
               check("rd_not_empty", 32'(empty), 32'd0);
               if (last_raddr == 3'd7 && raddr == 3'd0) wrap_seen = 1'b1;
               last_raddr = raddr;
            end
            if (chk_cnt) check("count_le2", 32'(dut.count <= 2'd2), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ----------------------------------------------------------- stimulus --
   initial begin
      logic [5:0] rd_seq;
      logic [5:0] vl_seq;
      int         pulses;
      int         pushed;
      int         budget;
      int         out_base;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      r_rst            = 1'b1;
      wbin             = 0;
      wptr_gray        = 4'b0110;
      out_if.out_ready = 1'b0;

      // Reset with a non-zero write pointer waiting at the synchronizer.
      repeat (2) cyc();
      r_rst = 1'b0;
      smp();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_rd_rq", 32'(rd_rq), 32'd0);
      check("rst_out_valid", 32'(out_if.out_valid), 32'd0);
      check("rst_out_data", 32'(out_if.out_data), 32'd0);
      check("rst_rptr_gray", 32'(rptr_gray), 32'd0);
      check("rst_raddr", 32'(raddr), 32'd0);
      cyc(); smp();
      check("rst_empty_sync1", 32'(empty), 32'd1);
      cyc(); smp();
      check("rst_empty_sync2", 32'(empty), 32'd1);
      check("rst_rptr_hold", 32'(rptr_gray), 32'd0);
      cyc(); smp();
      check("rst_empty_fall", 32'(empty), 32'd0);
      check("rst_first_rd", 32'(rd_rq), 32'd1);

      // Basic drain: A, B, C with the consumer always ready.
      do_reset();
      out_if.out_ready = 1'b1;
      push_word(4'hA);
      push_word(4'hB);
      push_word(4'hC);
      smp();
      check("drain_empty_e0", 32'(empty), 32'd1);
      cyc(); smp();
      check("drain_empty_e1", 32'(empty), 32'd1);
      cyc(); smp();
      check("drain_empty_e2", 32'(empty), 32'd1);
      cyc(); smp();
      check("drain_empty_e3", 32'(empty), 32'd0);
      for (int i = 0; i < 6; i++) begin
         rd_seq[i] = rd_rq;
         vl_seq[i] = out_if.out_valid;
         cyc(); smp();
      end
      check("drain_rd_pulses", 32'(rd_seq), 32'b000111);
      check("drain_valid_run", 32'(vl_seq), 32'b011100);
      check("drain_rptr_final", 32'(rptr_gray), 32'b0010);
      check("drain_empty_final", 32'(empty), 32'd1);
      check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure: five words, consumer stalled.
      cyc();
      out_if.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push_word(4'(i));
      pulses = 0;
      repeat (10) begin
         smp();
         if (rd_rq) pulses++;
         cyc();
      end
      check("bp_rd_pulses", 32'(pulses), 32'd2);
      smp();
      check("bp_valid", 32'(out_if.out_valid), 32'd1);
      check("bp_head", 32'(out_if.out_data), 32'h1);
      cyc();
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         smp();
         check("bp_stream_valid", 32'(out_if.out_valid), 32'd1);
         cyc();
      end
      smp();
      check("bp_stream_end", 32'(out_if.out_valid), 32'd0);
      check("bp_rptr_final", 32'(rptr_gray), 32'b1100);

      // Wrap-around: 20 words through the 8-entry memory from pointer 0.
      do_reset();
      out_if.out_ready = 1'b1;
      wrap_seen        = 1'b0;
      pushed           = 0;
      budget           = 0;
      while ((pushed < 20 || exp_q.size() != 0) && budget < 300) begin
         if (pushed < 20 && (wbin - rd_cnt) < DEPTH) begin
            push_word(4'((pushed * 7 + 3) & 15));
            pushed++;
         end
         cyc();
         budget++;
      end
      check("wrap_done_in_time", 32'(budget < 300), 32'd1);
      repeat (3) cyc();
      smp();
      check("wrap_raddr_7to0", 32'(wrap_seen), 32'd1);
      check("wrap_rptr_final", 32'(rptr_gray), 32'b0110);

      // Alternating consumer with a continuous supply.
      cyc();
      chk_cnt  = 1'b1;
      out_base = n_out;
      pushed   = 0;
      budget   = 0;
      while ((pushed < 12 || exp_q.size() != 0) && budget < 300) begin
         if (pushed < 12 && (wbin - rd_cnt) < DEPTH) begin
            push_word(4'((pushed * 5 + 9) & 15));
            pushed++;
         end
         out_if.out_ready = ~out_if.out_ready;
         cyc();
         budget++;
      end
      chk_cnt          = 1'b0;
      out_if.out_ready = 1'b1;
      check("alt_done_in_time", 32'(budget < 300), 32'd1);
      check("alt_word_count", 32'(n_out - out_base), 32'd12);

      // Reset while one word is queued and one read is in flight.
      cyc();
      out_if.out_ready = 1'b0;
      push_word(4'h7);
      push_word(4'h8);
      push_word(4'h9);
      repeat (5) cyc();
      r_rst     = 1'b1;
      wbin      = 0;
      wptr_gray = '0;
      exp_q.delete();
      smp();
      check("flush_pre_count", 32'(dut.count), 32'd1);
      check("flush_pre_pending", 32'(dut.pending), 32'd1);
      cyc();
      r_rst            = 1'b0;
      out_if.out_ready = 1'b1;
      out_base         = n_out;
      smp();
      check("flush_valid", 32'(out_if.out_valid), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_rptr_gray", 32'(rptr_gray), 32'd0);
      for (int i = 0; i < 6; i++) begin
         cyc(); smp();
         check("flush_no_output", 32'(out_if.out_valid), 32'd0);
      end
      check("flush_out_count", 32'(n_out - out_base), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
